// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the serial subtractor.
// The master offers operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 21
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b - bin, CHUNK bits per
// clock with the borrow carried between chunks in a flip-flop.
// Valid/ready on both sides; results are held until the consumer takes them.
module serial_subtractor #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned CHUNK = 3
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_chunk
        $error("serial_subtractor: WIDTH must be an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic              borrow;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              a_msb, b_msb;
    logic [WIDTH-1:0]  work_r, work_n;
    logic [CHUNK-1:0]  a_k, b_k;
    logic [CHUNK:0]    sub_k;
    logic [WIDTH-1:0]  diff_r;
    logic              bout_r, ovf_r;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_n = RUN;
            RUN:  if (cnt == LAST)  state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs derived from state.
    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = (state == DONE);
    end

    // One chunk subtract on the low bits of the operand shift registers.
    // Operands shift right and results shift in from the top, so after N
    // steps chunk k of the result sits at bits [k*CHUNK +: CHUNK].
    always_comb begin
        a_k    = a_r[CHUNK-1:0];
        b_k    = b_r[CHUNK-1:0];
        sub_k  = {1'b0, a_k} - {1'b0, b_k} - (CHUNK+1)'(borrow);
        work_n = (work_r >> CHUNK) | (WIDTH'(sub_k[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Datapath: operand capture, chunk stepping and result loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            borrow <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            work_r <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        borrow <= bus.bin;
                        cnt    <= '0;
                        work_r <= '0;
                    end
                end
                RUN: begin
                    a_r    <= a_r >> CHUNK;
                    b_r    <= b_r >> CHUNK;
                    borrow <= sub_k[CHUNK];
                    work_r <= work_n;
                    if (cnt == LAST) begin
                        diff_r <= work_n;
                        bout_r <= sub_k[CHUNK];
                        ovf_r  <= (a_msb ^ b_msb) & (work_n[WIDTH-1] ^ a_msb);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result outputs come straight from the result registers.
    always_comb begin
        bus.diff = diff_r;
        bus.bout = bout_r;
        bus.ovf  = ovf_r;
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at the default 21/3 size.
module tb_serial_subtractor;
    localparam int unsigned W = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .CHUNK(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operation, confirm latency and result; leaves block in DONE.
    task automatic start_and_wait(input string tag, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic binv,
                                  input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = av; bus.b = bv; bus.bin = binv; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        chk({tag, "_lat"},  32'(n), 32'd7);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(eo));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ovalid0"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_iready1"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b1; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;

        // Reset held two cycles with in_valid high.
        rst = 1'b1;
        tick();
        chk("rst_iready_c1", 32'(bus.in_ready), 32'd0);
        tick();
        chk("rst_iready_c2", 32'(bus.in_ready), 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("post_rst_iready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_diff",   32'(bus.diff), 32'd0);
        chk("post_rst_bout",   32'(bus.bout), 32'd0);
        chk("post_rst_ovf",    32'(bus.ovf),  32'd0);

        // Basic subtract: 100 - 58 = 42.
        start_and_wait("basic", 21'd100, 21'd58, 1'b0, 21'd42, 1'b0, 1'b0);
        drain("basic");

        // Wrap: 0 - 1.
        start_and_wait("wrap", 21'd0, 21'd1, 1'b0, 21'h1FFFFF, 1'b1, 1'b0);
        drain("wrap");

        // Signed overflow, positive minus negative.
        start_and_wait("ovf1", 21'h0FFFFF, 21'h1FFFFF, 1'b0, 21'h100000, 1'b1, 1'b1);
        drain("ovf1");

        // Signed overflow with borrow rippling through all chunks.
        start_and_wait("ovf2", 21'h100000, 21'h000001, 1'b1, 21'h0FFFFE, 1'b0, 1'b1);
        drain("ovf2");

        // All-zero operands with borrow-in.
        start_and_wait("zero_bin", 21'd0, 21'd0, 1'b1, 21'h1FFFFF, 1'b1, 1'b0);
        drain("zero_bin");

        // Equal operands.
        start_and_wait("equal", 21'h12345, 21'h12345, 1'b0, 21'd0, 1'b0, 1'b0);
        drain("equal");

        // Backpressure: result held for 5 cycles while inputs churn.
        start_and_wait("bp", 21'h01234, 21'h00234, 1'b0, 21'h01000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 21'($urandom); bus.b = 21'($urandom); bus.bin = 1'($urandom);
            tick();
            chk("bp_ovalid", 32'(bus.out_valid), 32'd1);
            chk("bp_iready", 32'(bus.in_ready), 32'd0);
            chk("bp_diff",   32'(bus.diff), 32'h01000);
        end
        bus.in_valid = 1'b0;
        drain("bp");
        chk("bp_hold_idle", 32'(bus.diff), 32'h01000);

        // Reset in the middle of RUN at counter 3.
        bus.a = 21'h15555; bus.b = 21'd1; bus.bin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("midrun_ovalid_pre", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        tick();
        chk("midrun_ovalid", 32'(bus.out_valid), 32'd0);
        chk("midrun_diff",   32'(bus.diff), 32'd0);
        chk("midrun_bout",   32'(bus.bout), 32'd0);
        chk("midrun_iready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrun_idle", 32'(bus.in_ready), 32'd1);
        start_and_wait("after_rst", 21'd7, 21'd7, 1'b0, 21'd0, 1'b0, 1'b0);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
